mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, cycles to wait for mem_ack before abort.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: ports clk and rst_n.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 if_req  in  1  fetch request; held with if_addr until if_valid.
REQ-008 if_addr  in  ADDR_W  fetch address.
REQ-009 if_rdata  out  DATA_W  fetched instruction; valid while if_valid=1.
REQ-010 if_valid  out  1  one-cycle fetch completion pulse.
REQ-011 d_req  in  1  data request (LDR/STR); held with d_we, d_addr, d_wdata until d_valid.
REQ-012 d_we  in  1  1=store, 0=load.
REQ-013 d_addr  in  ADDR_W  data address.
REQ-014 d_wdata  in  DATA_W  store data.
REQ-015 d_rdata  out  DATA_W  load data; valid while d_valid=1.
REQ-016 d_valid  out  1  one-cycle data completion pulse.
REQ-017 mem_req  out  1  memory access active.
REQ-018 mem_we, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  latched access fields.
REQ-019 mem_rdata  in  DATA_W  read data, sampled when mem_ack=1.
REQ-020 mem_ack  in  1  one-cycle access completion.
REQ-021 stall_f  out  1  if_req & ~if_valid (combinational).
REQ-022 stall_m  out  1  d_req & ~d_valid (combinational).
REQ-023 timeout_err  out  1  sticky abort indicator.

Function
REQ-024 FSM states SHALL be IDLE, GNT_I, GNT_D, RESP.
REQ-025 IDLE: only d_req -> GNT_D; only if_req -> GNT_I; both -> requester not granted last (last_grant register, reset = fetch, so data wins first contention); none -> IDLE.
REQ-026 On grant edge, mem_we/mem_addr/mem_wdata SHALL latch requester fields (fetch: mem_we=0, mem_wdata=0).
REQ-027 mem_req SHALL be 1 exactly in GNT_I/GNT_D.
REQ-028 GNT_x with mem_ack=1 SHALL latch mem_rdata into if_rdata or d_rdata and go to RESP.
REQ-029 RESP SHALL pulse the granted requester's valid for one cycle, then go to IDLE; no grant in RESP.
REQ-030 Minimum latency: req in IDLE at cycle N, mem_ack at N+1 -> valid at N+2.
REQ-031 mem_ack in IDLE or RESP SHALL be ignored.
REQ-032 Requester dropping req mid-access: access completes, valid still pulses.
REQ-033 if_rdata/d_rdata SHALL hold their last value between accesses; stores leave d_rdata unchanged.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE, last_grant=fetch, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, d_rdata=0, if_valid=0, d_valid=0, timeout_err=0, timeout counter=0.
REQ-035 Reset mid-access SHALL abandon the access with no valid pulse; a late mem_ack after release is ignored per REQ-031.

Configuration
REQ-036 Macro MEM_ARB_TIMEOUT_EN defined: counter clears on grant, increments each GNT_x cycle without mem_ack; on reaching TIMEOUT_CYCLES, go to RESP, drop mem_req, load 32'hDEADBEEF into the granted rdata, set timeout_err sticky until reset.
REQ-037 Macro undefined: no counter logic, timeout_err tied 0, GNT_x waits indefinitely.

Structure
REQ-038 Package mem_arb_pkg SHALL hold the state enum, grant enum (GRANT_I, GRANT_D), default widths, and ABORT_DATA=32'hDEADBEEF.
REQ-039 Sub-module mem_arb_timeout (counter, clear/enable in, expire out) SHALL be instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-040 Fetch only: if_addr=0x100, mem_ack one cycle after mem_req, mem_rdata=0xE2811001 -> if_valid at N+2, if_rdata=0xE2811001, stall_f high N..N+1.
REQ-041 Contention: if_req and d_req (load 0x200) same cycle after reset -> data granted first, fetch next; then both again -> fetch first.
REQ-042 Store: d_we=1, d_addr=0x204, d_wdata=0x55 -> mem_we=1, mem_addr=0x204, mem_wdata=0x55 during GNT_D; d_rdata unchanged.
REQ-043 Slow memory: mem_ack after 10 cycles -> mem_req high 10 cycles, stall_m high throughout, single d_valid.
REQ-044 Reset mid-access at GNT_I cycle 3 -> all outputs zero immediately; mem_ack after release gives no valid.
REQ-045 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no mem_ack -> abort after 8 GNT cycles, d_rdata=0xDEADBEEF, timeout_err stays 1 until rst_n=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_timeout.sv
// Access watchdog: counts granted cycles without mem_ack, flags expiry on the last allowed one.
module mem_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // The cycle that would bring the count to TIMEOUT_CYCLES is the abort cycle.
    assign expire = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch and data requesters with alternating priority.
// Optional access watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_f,
    output logic              stall_m,
    output logic              timeout_err
);

    localparam logic [DATA_W-1:0] ABORT_WORD = DATA_W'(ABORT_DATA);

    arb_state_e state, state_nxt;
    grant_e     last_grant;
    logic       granted;
    logic       expire;

    assign granted = (state == GNT_I) || (state == GNT_D);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // On contention the requester that did not win last time goes first.
                if (d_req && (!if_req || last_grant == GRANT_I)) begin
                    state_nxt = GNT_D;
                end else if (if_req) begin
                    state_nxt = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ack || expire) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == GNT_I) begin
                last_grant <= GRANT_I;
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                mem_wdata  <= '0;
            end
            if (state == IDLE && state_nxt == GNT_D) begin
                last_grant <= GRANT_D;
                mem_we     <= d_we;
                mem_addr   <= d_addr;
                mem_wdata  <= d_wdata;
            end
            if (granted) begin
                if (mem_ack) begin
                    if (state == GNT_I) begin
                        if_rdata <= mem_rdata;
                    end else if (!mem_we) begin
                        d_rdata <= mem_rdata;
                    end
                end else if (expire) begin
                    if (state == GNT_I) begin
                        if_rdata <= ABORT_WORD;
                    end else begin
                        d_rdata <= ABORT_WORD;
                    end
                end
            end
        end
    end

    assign mem_req  = granted;
    assign if_valid = (state == RESP) && (last_grant == GRANT_I);
    assign d_valid  = (state == RESP) && (last_grant == GRANT_D);
    assign stall_f  = if_req & ~if_valid;
    assign stall_m  = d_req & ~d_valid;

`ifdef MEM_ARB_TIMEOUT_EN
    logic grant_edge;

    assign grant_edge = (state == IDLE) && (state_nxt != IDLE);

    mem_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (grant_edge),
        .en    (granted && !mem_ack),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (expire) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, d_req, d_we, mem_ack;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          if_valid, d_valid, mem_req, mem_we, stall_f, stall_m, timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_f(stall_f), .stall_m(stall_m), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks after a chosen number of granted cycles, plus stray acks.
    bit            rand_mem = 1'b0;
    bit            force_ack = 1'b0;
    int            fixed_delay = 0;
    logic [DW-1:0] fixed_rdata = '0;
    int            ack_age = 0;
    int            ack_delay = 0;

    always @(posedge clk) begin
        #1;
        mem_ack   = 1'b0;
        mem_rdata = rand_mem ? DW'($urandom) : fixed_rdata;
        if (force_ack) begin
            mem_ack = 1'b1;
        end else if (mem_req) begin
            if (ack_age == 0)
                ack_delay = rand_mem ? int'($urandom_range(0, TO_EN ? 10 : 6)) : fixed_delay;
            if (ack_age == ack_delay) mem_ack = 1'b1;
            ack_age++;
        end else begin
            ack_age = 0;
            if (rand_mem && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
        end
    end

    // Transaction model: port is free, busy with one owner's access, or handing back the result.
    int            m_phase;
    bit            m_own_d, m_last_d;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_if_rdata, m_d_rdata;
    bit            m_terr;
    int            m_wait;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_own_d = 0; m_last_d = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            m_if_rdata = '0; m_d_rdata = '0; m_terr = 0; m_wait = 0;
        end else begin
            case (m_phase)
                0: if (if_req || d_req) begin
                    m_own_d  = d_req && !(if_req && m_last_d);
                    m_last_d = m_own_d;
                    m_wait   = 0;
                    m_phase  = 1;
                    m_we     = m_own_d ? d_we : 1'b0;
                    m_addr   = m_own_d ? d_addr : if_addr;
                    m_wdata  = m_own_d ? d_wdata : '0;
                end
                1: if (mem_ack) begin
                    if (!m_own_d) m_if_rdata = mem_rdata;
                    else if (!m_we) m_d_rdata = mem_rdata;
                    m_phase = 2;
                end else begin
                    m_wait++;
                    if (TO_EN && m_wait == TO) begin
                        if (m_own_d) m_d_rdata = 32'hDEADBEEF;
                        else m_if_rdata = 32'hDEADBEEF;
                        m_terr  = 1;
                        m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    bit cmp_on = 1'b0;

    always @(negedge clk) begin
        if (cmp_on) begin
            check("mem_req", mem_req, m_phase == 1);
            check("mem_we", mem_we, m_we);
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
            check("if_valid", if_valid, m_phase == 2 && !m_own_d);
            check("d_valid", d_valid, m_phase == 2 && m_own_d);
            check("if_rdata", if_rdata, m_if_rdata);
            check("d_rdata", d_rdata, m_d_rdata);
            check("stall_f", stall_f, if_req && !(m_phase == 2 && !m_own_d));
            check("stall_m", stall_m, d_req && !(m_phase == 2 && m_own_d));
            check("timeout_err", timeout_err, m_terr);
        end
    end

    task automatic rand_cycle();
        bit fdone, ddone;
        @(negedge clk);
        fdone = if_valid;
        ddone = d_valid;
        tick();
        if (if_req) begin
            if (fdone || $urandom_range(0, 31) == 0) if_req = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = AW'($urandom);
        end
        if (d_req) begin
            if (ddone || $urandom_range(0, 31) == 0) d_req = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
            d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
            d_addr = AW'($urandom); d_wdata = DW'($urandom);
        end
    endtask

    logic [AW-1:0] seq_addr [4] = '{32'h200, 32'h100, 32'h200, 32'h100};

    initial begin
        int mr, dv, sm;
        rst_n = 1'b0;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        cmp_on = 1'b1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_valids", {if_valid, d_valid, timeout_err}, 0);
        tick(); rst_n = 1'b1;

        // Single fetch with minimum latency
        fixed_delay = 0; fixed_rdata = 32'hE2811001;
        tick(); if_req = 1; if_addr = 32'h100;
        @(negedge clk); check("f_stall_n", stall_f, 1); check("f_req_n", mem_req, 0);
        tick(); @(negedge clk);
        check("f_req_n1", mem_req, 1); check("f_addr_n1", mem_addr, 32'h100); check("f_stall_n1", stall_f, 1);
        tick(); @(negedge clk);
        check("f_valid_n2", if_valid, 1); check("f_rdata_n2", if_rdata, 32'hE2811001); check("f_stall_n2", stall_f, 0);
        tick(); if_req = 0;

        // Contention alternates, data first after reset
        fixed_rdata = 32'h11112222;
        tick(); if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            tick(); @(negedge clk);
            check("arb_addr", mem_addr, seq_addr[k]);
            tick(); @(negedge clk);
            check("arb_dvalid", d_valid, (k % 2) == 0);
            check("arb_ivalid", if_valid, (k % 2) == 1);
            tick();
        end
        if_req = 0; d_req = 0;
        check("arb_d_rdata", d_rdata, 32'h11112222);

        // Store leaves d_rdata alone
        fixed_rdata = 32'hFFFFFFFF;
        tick(); d_req = 1; d_we = 1; d_addr = 32'h204; d_wdata = 32'h55;
        tick(); @(negedge clk);
        check("st_we", mem_we, 1); check("st_addr", mem_addr, 32'h204); check("st_wdata", mem_wdata, 32'h55);
        tick(); @(negedge clk);
        check("st_valid", d_valid, 1); check("st_rdata", d_rdata, 32'h11112222);
        tick(); d_req = 0; d_we = 0;

        // Slow memory: ack on the tenth granted cycle
        fixed_delay = 9; fixed_rdata = 32'hCAFEF00D;
        tick(); d_req = 1; d_addr = 32'h300;
        mr = 0; dv = 0; sm = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) mr++;
            if (d_valid) dv++;
            if (stall_m) sm++;
            tick();
            if (dv != 0) d_req = 0;
        end
        check("slow_req_cycles", mr, 10); check("slow_valids", dv, 1);
        check("slow_stall_cycles", sm, 11); check("slow_rdata", d_rdata, 32'hCAFEF00D);

`ifdef MEM_ARB_TIMEOUT_EN
        // Abort after TO granted cycles with no ack
        fixed_delay = 1000;
        tick(); d_req = 1; d_addr = 32'h400;
        mr = 0; dv = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (mem_req) mr++;
            if (d_valid) dv++;
            tick();
            if (dv != 0) d_req = 0;
        end
        check("to_req_cycles", mr, TO); check("to_valids", dv, 1);
        check("to_rdata", d_rdata, 32'hDEADBEEF); check("to_err", timeout_err, 1);
        fixed_delay = 0;
        tick(); if_req = 1; if_addr = 32'h104;
        repeat (3) tick();
        if_req = 0;
        @(negedge clk); check("to_err_sticky", timeout_err, 1);
        #1 rst_n = 0; #1 check("to_err_rst", timeout_err, 0);
        tick(); rst_n = 1;
`else
        check("to_err_tied", timeout_err, 0);
`endif

        // Reset during the third granted cycle of a fetch
        fixed_delay = 50;
        tick(); if_req = 1; if_addr = 32'h1F0;
        repeat (3) tick();
        @(negedge clk); check("rm_req_before", mem_req, 1);
        #1 rst_n = 0;
        #1;
        check("rm_req", mem_req, 0); check("rm_addr", mem_addr, 0);
        check("rm_out", {mem_we, if_valid, d_valid, timeout_err}, 0);
        check("rm_rdata", {if_rdata, d_rdata, mem_wdata}, 0);
        if_req = 0;
        tick(); rst_n = 1;
        @(negedge clk); force_ack = 1;
        @(negedge clk); force_ack = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rm_late_ack", {mem_req, if_valid, d_valid}, 0);
        end

        // Randomized traffic with occasional asynchronous resets
        rand_mem = 1;
        for (int i = 0; i < 3000; i++) begin
            rand_cycle();
            if (i % 500 == 499) begin
                #2 rst_n = 0;
                #3 rst_n = 1;
            end
        end
        rand_mem = 0;
        if_req = 0; d_req = 0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
